rename_freelist: RTL and testbench

- Integer physical-register free list. Sits directly upstream of the rename map stage.
- Supplies the per-slot allocated physical destination indices for renaming.
- Takes back the physical indices that the map stage releases after commit.
- Keeps a speculative and an architectural read head, so a squash restores allocation state in one cycle.

---
 rtl/rename_freelist.sv | 159 +++++++++++++++
 tb/tb_rename_freelist.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_freelist.sv
// rename_freelist: integer physical-register free list with speculative/arch heads.
// Optional FREELIST_DUP_CHECK_EN adds an in-list bitmap and a sticky o_dup_err.
module rename_freelist #(
  parameter int WIDTH      = 4,
  parameter int COMMIT_WID = 4,
  parameter int NUM_PHYREG = 128,
  localparam int IDX_W     = $clog2(NUM_PHYREG),
  localparam int PTR_W     = IDX_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 i_alloc_req,
  input  logic                             i_alloc_fire,
  output logic                             o_can_alloc,
  output logic [WIDTH-1:0][IDX_W-1:0]      o_alloc_prd_idx,
  input  logic                             i_squash_vld,
  input  logic [COMMIT_WID-1:0]            i_commit_alloc,
  input  logic [COMMIT_WID-1:0]            i_dealloc_vld,
  input  logic [COMMIT_WID-1:0][IDX_W-1:0] i_dealloc_prd_idx,
`ifdef FREELIST_DUP_CHECK_EN
  output logic                             o_dup_err,
`endif
  output logic [PTR_W-1:0]                 o_free_count
);

  logic [IDX_W-1:0] mem [NUM_PHYREG];
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] arch_head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] arch_nxt;
  logic [PTR_W-1:0] commit_cnt;
  logic [PTR_W-1:0] alloc_off [WIDTH+1];
  logic [PTR_W-1:0] dealloc_off [COMMIT_WID+1];
  logic             alloc_go;

  // Prefix counts give each requesting slot its rank in the group
  always_comb begin
    alloc_off[0] = '0;
    for (int s = 0; s < WIDTH; s++)
      alloc_off[s+1] = alloc_off[s] + PTR_W'(i_alloc_req[s]);
  end

  always_comb begin
    dealloc_off[0] = '0;
    for (int s = 0; s < COMMIT_WID; s++)
      dealloc_off[s+1] = dealloc_off[s] + PTR_W'(i_dealloc_vld[s]);
  end

  always_comb begin
    commit_cnt = '0;
    for (int s = 0; s < COMMIT_WID; s++)
      commit_cnt = commit_cnt + PTR_W'(i_commit_alloc[s]);
  end

  assign arch_nxt     = arch_head + commit_cnt;
  assign o_free_count = tail - spec_head;
  assign o_can_alloc  = o_free_count >= alloc_off[WIDTH];
  assign alloc_go     = i_alloc_fire & o_can_alloc & ~i_squash_vld;

  always_comb begin
    for (int s = 0; s < WIDTH; s++)
      o_alloc_prd_idx[s] = i_alloc_req[s]
        ? mem[IDX_W'(spec_head + alloc_off[s])] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PHYREG; i++)
        mem[i] <= (i < NUM_PHYREG-1) ? IDX_W'(i + 1) : '0;
    end else begin
      for (int s = 0; s < COMMIT_WID; s++)
        if (i_dealloc_vld[s])
          mem[IDX_W'(tail + dealloc_off[s])] <= i_dealloc_prd_idx[s];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= PTR_W'(NUM_PHYREG - 1);
    end else begin
      arch_head <= arch_nxt;
      tail      <= tail + dealloc_off[COMMIT_WID];
      if (i_squash_vld)
        spec_head <= arch_nxt;
      else if (alloc_go)
        spec_head <= spec_head + alloc_off[WIDTH];
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [NUM_PHYREG-1:0] in_list;
  logic [NUM_PHYREG-1:0] in_list_nxt;
  logic [NUM_PHYREG-1:0] dmask;
  logic [PTR_W-1:0]      sq_len;
  logic                  dup_hit;

  assign sq_len = spec_head - arch_nxt;

  // Squash returns the uncommitted window [arch_nxt, spec_head) to the list
  always_comb begin
    in_list_nxt = in_list;
    dmask       = '0;
    dup_hit     = 1'b0;
    if (i_squash_vld) begin
      for (int i = 0; i < NUM_PHYREG; i++)
        if ({1'b0, IDX_W'(IDX_W'(i) - arch_nxt[IDX_W-1:0])} < sq_len)
          in_list_nxt[mem[i]] = 1'b1;
    end else if (alloc_go) begin
      for (int s = 0; s < WIDTH; s++)
        if (i_alloc_req[s])
          in_list_nxt[o_alloc_prd_idx[s]] = 1'b0;
    end
    for (int s = 0; s < COMMIT_WID; s++)
      if (i_dealloc_vld[s]) begin
        if (in_list[i_dealloc_prd_idx[s]] | dmask[i_dealloc_prd_idx[s]])
          dup_hit = 1'b1;
        dmask[i_dealloc_prd_idx[s]] = 1'b1;
      end
    in_list_nxt = in_list_nxt | dmask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_list   <= {{(NUM_PHYREG-1){1'b1}}, 1'b0};
      o_dup_err <= 1'b0;
    end else begin
      in_list   <= in_list_nxt;
      o_dup_err <= o_dup_err | dup_hit;
    end
  end

`ifndef SYNTHESIS
  a_dup: assert property (@(posedge clk) disable iff (!rst) !dup_hit);
`endif
`endif

`ifndef SYNTHESIS
  logic zero_rel;
  always_comb begin
    zero_rel = 1'b0;
    for (int s = 0; s < COMMIT_WID; s++)
      if (i_dealloc_vld[s] && i_dealloc_prd_idx[s] == '0)
        zero_rel = 1'b1;
  end

  a_fire: assert property (@(posedge clk) disable iff (!rst)
    i_alloc_fire |-> o_can_alloc);
  a_zero: assert property (@(posedge clk) disable iff (!rst) !zero_rel);
  a_occ: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(tail - arch_head) <= PTR_W'(NUM_PHYREG - 1));
  a_arch: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(spec_head - arch_head) <= PTR_W'(NUM_PHYREG - 1));
  a_cmt: assert property (@(posedge clk) disable iff (!rst)
    commit_cnt <= PTR_W'(spec_head - arch_head));
`endif

endmodule

// File: tb/tb_rename_freelist.sv
// tb_rename_freelist: directed stimulus with a queue scoreboard.
// A negedge monitor pops expectations and compares them to live DUT outputs.
module tb_rename_freelist;

  localparam int IW = 7;
  localparam int PW = 8;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [3:0]        i_alloc_req;
  logic              i_alloc_fire;
  logic              o_can_alloc;
  logic [3:0][IW-1:0] o_alloc_prd_idx;
  logic              i_squash_vld;
  logic [3:0]        i_commit_alloc;
  logic [3:0]        i_dealloc_vld;
  logic [3:0][IW-1:0] i_dealloc_prd_idx;
  logic [PW-1:0]     o_free_count;
`ifdef FREELIST_DUP_CHECK_EN
  logic              o_dup_err;
`endif

  exp_t sb[$];
  exp_t e;
  logic [31:0] act;
  int n_chk = 0;
  int n_fail = 0;

  rename_freelist dut (
    .clk               (clk),
    .rst               (rst),
    .i_alloc_req       (i_alloc_req),
    .i_alloc_fire      (i_alloc_fire),
    .o_can_alloc       (o_can_alloc),
    .o_alloc_prd_idx   (o_alloc_prd_idx),
    .i_squash_vld      (i_squash_vld),
    .i_commit_alloc    (i_commit_alloc),
    .i_dealloc_vld     (i_dealloc_vld),
    .i_dealloc_prd_idx (i_dealloc_prd_idx),
`ifdef FREELIST_DUP_CHECK_EN
    .o_dup_err         (o_dup_err),
`endif
    .o_free_count      (o_free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0: act = {4'b0, o_alloc_prd_idx};
        1: act = {31'b0, o_can_alloc};
        2: act = {24'b0, o_free_count};
`ifdef FREELIST_DUP_CHECK_EN
        3: act = {31'b0, o_dup_err};
`endif
        default: act = 32'hdead_beef;
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
      end
    end
  end

  function automatic logic [27:0] pk(int a, int b, int c, int d);
    return {IW'(d), IW'(c), IW'(b), IW'(a)};
  endfunction

  task automatic put(string n, int k, logic [31:0] v);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic drive(logic [3:0] req, logic fire, logic sq,
                       logic [3:0] cm, logic [3:0] dv, logic [27:0] di);
    i_alloc_req       = req;
    i_alloc_fire      = fire;
    i_squash_vld      = sq;
    i_commit_alloc    = cm;
    i_dealloc_vld     = dv;
    i_dealloc_prd_idx = di;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 28'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    put("rst_count", 2, 127);
    put("rst_can", 1, 1);
    put("rst_idx", 0, 0);
`ifdef FREELIST_DUP_CHECK_EN
    put("rst_dup", 3, 0);
`endif
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    tick();
    do_reset();

    // basic sparse allocation
    drive(4'b1011, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("alloc_1011_idx", 0, {4'b0, pk(1, 2, 0, 3)});
    put("alloc_1011_can", 1, 1);
    tick();
    idle();
    put("count_after_3", 2, 124);
    tick();

    // mid-operation reset, then drain to empty
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive(4'b1111, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
      if (i % 10 == 0)
        put("drain_idx", 0, {4'b0, pk(4*i+1, 4*i+2, 4*i+3, 4*i+4)});
      tick();
    end
    drive(4'b1111, 1'b0, 1'b0, 4'b0, 4'b0, 28'b0);
    put("short_can", 1, 0);
    put("short_count", 2, 3);
    tick();
    drive(4'b0111, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("last3_can", 1, 1);
    put("last3_idx", 0, {4'b0, pk(125, 126, 127, 0)});
    tick();
    idle();
    put("empty_count", 2, 0);
    put("empty_noreq_can", 1, 1);
    tick();
    drive(4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 28'b0);
    put("empty_req_can", 1, 0);
    tick();

    // commit everything, then release two with tail wrap
    for (int i = 0; i < 31; i++) begin
      drive(4'b0, 1'b0, 1'b0, 4'b1111, 4'b0, 28'b0);
      tick();
    end
    drive(4'b0, 1'b0, 1'b0, 4'b0111, 4'b0, 28'b0);
    tick();
    drive(4'b0, 1'b0, 1'b0, 4'b0, 4'b0101, pk(40, 0, 9, 0));
    put("dealloc_same_cyc", 2, 0);
    tick();
    drive(4'b0011, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("dealloc_count", 2, 2);
    put("dealloc_can", 1, 1);
    put("wrap_idx", 0, {4'b0, pk(40, 9, 0, 0)});
    tick();
    idle();
    put("wrap_empty", 2, 0);
    tick();

    // squash recovery
    do_reset();
    drive(4'b1111, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    tick();
    drive(4'b1111, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    tick();
    drive(4'b0011, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("ten_idx", 0, {4'b0, pk(9, 10, 0, 0)});
    tick();
    drive(4'b0, 1'b0, 1'b1, 4'b1111, 4'b0, 28'b0);
    put("pre_squash_count", 2, 117);
    tick();
    drive(4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("squash_idx", 0, {4'b0, pk(5, 0, 0, 0)});
    put("squash_count", 2, 123);
    tick();
    drive(4'b0111, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("refill_idx", 0, {4'b0, pk(6, 7, 8, 0)});
    tick();
    drive(4'b0, 1'b0, 1'b1, 4'b0011, 4'b0, 28'b0);
    tick();
    drive(4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    put("sq_commit_idx", 0, {4'b0, pk(7, 0, 0, 0)});
    put("sq_commit_count", 2, 121);
    tick();
    drive(4'b0001, 1'b1, 1'b1, 4'b0, 4'b0, 28'b0);
    put("sq_fire_idx", 0, {4'b0, pk(8, 0, 0, 0)});
    tick();
    drive(4'b0001, 1'b0, 1'b0, 4'b0, 4'b0, 28'b0);
    put("dropped_fire_idx", 0, {4'b0, pk(7, 0, 0, 0)});
    put("dropped_fire_count", 2, 121);
    tick();

`ifdef FREELIST_DUP_CHECK_EN
    do_reset();
    drive(4'b0001, 1'b1, 1'b0, 4'b0, 4'b0, 28'b0);
    tick();
    drive(4'b0, 1'b0, 1'b0, 4'b0001, 4'b0, 28'b0);
    tick();
    drive(4'b0, 1'b0, 1'b0, 4'b0, 4'b0001, pk(50, 0, 0, 0));
    put("dup_pre", 3, 0);
    tick();
    idle();
    put("dup_set", 3, 1);
    tick();
    put("dup_sticky", 3, 1);
    tick();
    do_reset();
`endif

    idle();
    tick();
    tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
